multicycle_datapath: RTL and testbench
======================================

MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

Interface
REQ-001 Parameter ADDR_W, default 32: memory address width, legal range 8..32.
REQ-002 Parameter RESET_PC, default 0: PC value loaded at reset.
REQ-003 Parameter PC_STEP, default 4: PC increment per instruction; 4 means byte-addressed memory, 1 means word-addressed memory.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 reset  input  1  reset; asynchronous, active-low; 0 clears all state immediately.
REQ-006 memory_addr  output  ADDR_W  shared instruction/data address.
REQ-007 memory_rden  output  1  read request; held until memory_response.
REQ-008 memory_wren  output  1  write request; held until memory_response.
REQ-009 memory_read_val  input  32  read data; valid when memory_response=1.
REQ-010 memory_write_val  output  32  store data; valid while memory_wren=1.
REQ-011 memory_response  input  1  single-cycle completion strobe for the outstanding request.
REQ-012 OpCode  output  6  instruction register bits [31:26].
REQ-013 state  output  3  current FSM state encoding.
REQ-014 halted  output  1  1 while in HALT.
REQ-015 retired  output  1  single-cycle pulse on instruction completion.

Function
REQ-016 The FSM SHALL use FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; encodings 6 and 7 go to HALT.
REQ-017 FETCH: memory_rden=1, memory_addr=PC; on the memory_response edge, IR<=memory_read_val, PC<=PC+PC_STEP, next state DECODE.
REQ-018 DECODE: A<=R[rs], B<=R[rt], imm<=sign-extended IR[15:0]; unsupported opcode or funct goes to HALT.
REQ-019 Supported opcodes: R-type 0x00 with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A; lw 0x23; sw 0x2B; beq 0x04; addi 0x08; j 0x02; halt 0x3F.
REQ-020 EXEC: compute ALUout; R-type and addi go to WB; lw and sw go to MEM; beq and j go to FETCH.
REQ-021 beq: if A==B, PC<=PC+imm*PC_STEP, using the already-incremented PC; otherwise PC is unchanged.
REQ-022 j: PC<=(IR[25:0]*PC_STEP) truncated to ADDR_W.
REQ-023 halt: EXEC goes to HALT; halt is counted as retired.
REQ-024 Arithmetic SHALL wrap modulo 2^32 with no overflow trap; slt is a signed compare giving 1 or 0.
REQ-025 MEM, lw: memory_rden=1, memory_addr=ALUout[ADDR_W-1:0]; on memory_response, MDR<=memory_read_val, next state WB.
REQ-026 MEM, sw: memory_wren=1, memory_write_val=B; on memory_response, next state FETCH.
REQ-027 WB: R-type writes R[rd]; addi writes R[rt]; lw writes R[rt] with MDR; next state FETCH.
REQ-028 The register file SHALL be 32x32 and internal; R0 always reads 0; writes to R0 are discarded.
REQ-029 memory_rden and memory_wren SHALL never both be 1; both are 0 outside FETCH and MEM.
REQ-030 memory_addr=0 when no request is active.
REQ-031 memory_response with no request outstanding SHALL be ignored.
REQ-032 The FSM waits indefinitely in FETCH or MEM until memory_response arrives.
REQ-033 retired SHALL pulse on the edge leaving EXEC (beq, j, halt), leaving MEM (sw) or leaving WB.
REQ-034 Zero-wait latency (response in the first request cycle): R-type/addi 4 cycles, lw 5, sw 4, beq/j 3.
REQ-035 HALT is sticky until reset: halted=1, no memory requests, no register writes.

Reset
REQ-036 While reset=0: state=FETCH, PC=RESET_PC, IR=0, A=B=MDR=ALUout=0, all registers 0.
REQ-037 While reset=0 all outputs are 0: memory_rden, memory_wren, memory_addr, memory_write_val, OpCode, halted, retired.
REQ-038 Reset asserted mid-access SHALL drop memory_rden/memory_wren asynchronously; a later memory_response is ignored.
REQ-039 After release, the first FETCH requests RESET_PC on the first clock edge.

Verification
REQ-040 Zero-wait memory, program addi r1,r0,5; addi r2,r0,7; add r3,r1,r2; halt -> r3=12, retired pulses 4 times, halted=1 after cycle 15.
REQ-041 sw r3,0x10(r0) then lw r4,0x10(r0) -> wren with addr 0x10, data 12; then r4=12; never rden=wren=1.
REQ-042 beq r1,r1,-1 at PC 0x8 -> PC returns to 0x8 forever; beq r1,r2,+2 with r1!=r2 -> PC=0xC.
REQ-043 memory_response delayed 3 cycles on every access -> identical register results; rden held 4 cycles per fetch.
REQ-044 Opcode 0x3E, or R-type funct 0x00 -> HALT, halted=1, no further requests; reset pulse -> FETCH at RESET_PC.
REQ-045 Spurious memory_response in DECODE; addi r0,r0,9; slt with -1<1 -> state unaffected, r0=0, result 1.

Source files
------------

// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-subset datapath: FETCH/DECODE/EXEC/MEM/WB controller sharing one memory port.
// Memory-side and status outputs are registered, computed from the next state each cycle.
module multicycle_datapath #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] memory_addr,
  output logic              memory_rden,
  output logic              memory_wren,
  input  logic [31:0]       memory_read_val,
  output logic [31:0]       memory_write_val,
  input  logic              memory_response,
  output logic [5:0]        OpCode,
  output logic [2:0]        state,
  output logic              halted,
  output logic              retired
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d, a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [31:0]       alu_q, alu_d, mdr_q, mdr_d;
  logic [31:0]       regs [32];
  logic              rf_we;
  logic [4:0]        rf_wa;
  logic [31:0]       rf_wd;
  logic              rden_d, wren_d, halted_d, retired_d;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       wval_d;
  logic [5:0]        op, funct;
  logic [4:0]        rs, rt, rd;
  logic              req_done, supported;
  logic [31:0]       br_off, j_tgt;

  assign op     = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign funct  = ir_q[5:0];
  assign br_off = imm_q * 32'(PC_STEP);
  assign j_tgt  = {6'd0, ir_q[25:0]} * 32'(PC_STEP);
  // A response only counts while one of our own requests is on the bus.
  assign req_done = memory_response && (memory_rden || memory_wren);

  assign OpCode = ir_q[31:26];
  assign state  = state_q;

  always_comb begin
    case (op)
      OP_RTYPE: supported = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
      OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW, OP_HALT: supported = 1'b1;
      default:  supported = 1'b0;
    endcase
  end

  // Next-state, datapath register updates and registered-output next values.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    imm_d     = imm_q;
    alu_d     = alu_q;
    mdr_d     = mdr_q;
    rf_we     = 1'b0;
    rf_wa     = '0;
    rf_wd     = '0;
    retired_d = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (req_done) begin
          ir_d    = memory_read_val;
          pc_d    = pc_q + ADDR_W'(PC_STEP);
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        a_d     = (rs == 5'd0) ? '0 : regs[rs];
        b_d     = (rt == 5'd0) ? '0 : regs[rt];
        imm_d   = {{16{ir_q[15]}}, ir_q[15:0]};
        state_d = supported ? ST_EXEC : ST_HALT;
      end
      ST_EXEC: begin
        case (op)
          OP_RTYPE: begin
            case (funct)
              FN_ADD:  alu_d = a_q + b_q;
              FN_SUB:  alu_d = a_q - b_q;
              FN_AND:  alu_d = a_q & b_q;
              FN_OR:   alu_d = a_q | b_q;
              default: alu_d = ($signed(a_q) < $signed(b_q)) ? 32'd1 : 32'd0;
            endcase
            state_d = ST_WB;
          end
          OP_ADDI: begin
            alu_d   = a_q + imm_q;
            state_d = ST_WB;
          end
          OP_LW, OP_SW: begin
            alu_d   = a_q + imm_q;
            state_d = ST_MEM;
          end
          OP_BEQ: begin
            if (a_q == b_q) pc_d = pc_q + ADDR_W'(br_off);
            retired_d = 1'b1;
            state_d   = ST_FETCH;
          end
          OP_J: begin
            pc_d      = ADDR_W'(j_tgt);
            retired_d = 1'b1;
            state_d   = ST_FETCH;
          end
          default: begin
            retired_d = 1'b1;
            state_d   = ST_HALT;
          end
        endcase
      end
      ST_MEM: begin
        if (req_done) begin
          if (op == OP_LW) begin
            mdr_d   = memory_read_val;
            state_d = ST_WB;
          end else begin
            retired_d = 1'b1;
            state_d   = ST_FETCH;
          end
        end
      end
      ST_WB: begin
        rf_we     = 1'b1;
        rf_wa     = (op == OP_RTYPE) ? rd : rt;
        rf_wd     = (op == OP_LW) ? mdr_q : alu_q;
        retired_d = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase

    rden_d   = (state_d == ST_FETCH) || ((state_d == ST_MEM) && (op == OP_LW));
    wren_d   = (state_d == ST_MEM) && (op == OP_SW);
    halted_d = (state_d == ST_HALT);
    addr_d   = '0;
    if (state_d == ST_FETCH)           addr_d = pc_d;
    else if (rden_d || wren_d)         addr_d = alu_d[ADDR_W-1:0];
    wval_d   = wren_d ? b_d : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_FETCH;
      pc_q             <= RESET_PC;
      ir_q             <= '0;
      a_q              <= '0;
      b_q              <= '0;
      imm_q            <= '0;
      alu_q            <= '0;
      mdr_q            <= '0;
      memory_rden      <= 1'b0;
      memory_wren      <= 1'b0;
      memory_addr      <= '0;
      memory_write_val <= '0;
      halted           <= 1'b0;
      retired          <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      ir_q             <= ir_d;
      a_q              <= a_d;
      b_q              <= b_d;
      imm_q            <= imm_d;
      alu_q            <= alu_d;
      mdr_q            <= mdr_d;
      memory_rden      <= rden_d;
      memory_wren      <= wren_d;
      memory_addr      <= addr_d;
      memory_write_val <= wval_d;
      halted           <= halted_d;
      retired          <= retired_d;
    end
  end

  // Register file; R0 is never written so it always reads zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (rf_we && (rf_wa != 5'd0)) begin
      regs[rf_wa] <= rf_wd;
    end
  end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Scoreboard bench for multicycle_datapath: an ISA-level model predicts every bus transaction,
// retirement count and halt cycle; a memory responder adds wait states and spurious strobes.
module tb_multicycle_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] memory_addr;
  logic        memory_rden, memory_wren;
  logic [31:0] memory_read_val;
  logic [31:0] memory_write_val;
  logic        memory_response;
  logic [5:0]  OpCode;
  logic [2:0]  state;
  logic        halted, retired;

  always #5 clk = ~clk;

  multicycle_datapath dut (
    .clk(clk), .reset(reset), .memory_addr(memory_addr), .memory_rden(memory_rden),
    .memory_wren(memory_wren), .memory_read_val(memory_read_val),
    .memory_write_val(memory_write_val), .memory_response(memory_response),
    .OpCode(OpCode), .state(state), .halted(halted), .retired(retired)
  );

  typedef struct packed {
    logic        w;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q [$];
  logic [31:0] mem   [1024];
  logic [31:0] m_mem [1024];
  logic [31:0] prog  [$];
  int checks = 0, errors = 0;
  int dly = 0, rcnt = 0, cyc = 0, halt_cyc = -1, ret_cnt = 0, halt_reqs = 0;
  int exp_cyc, exp_ret;
  bit exp_halts;

  localparam logic [31:0] HALT_INS = {6'h3F, 26'd0};

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, got, want, $time);
    end
  endtask

  function automatic logic [31:0] rins(input logic [5:0] fn, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] iins(input logic [5:0] op, input logic [4:0] rt,
                                       input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Memory responder: answers after dly wait cycles, strobes response randomly when idle.
  always @(negedge clk) begin
    memory_response = 1'b0;
    memory_read_val = $urandom;
    if (!reset) begin
      rcnt = 0;
    end else if (memory_rden || memory_wren) begin
      if (rcnt >= dly) begin
        memory_response = 1'b1;
        rcnt = 0;
        if (memory_wren) mem[memory_addr[11:2]] = memory_write_val;
        else memory_read_val = mem[memory_addr[11:2]];
      end else begin
        rcnt++;
      end
    end else begin
      rcnt = 0;
      memory_response = ($urandom_range(0, 2) == 0);
    end
  end

  always @(posedge clk) begin
    if (!reset) cyc = 0;
    else cyc++;
  end

  // Monitor: pops the scoreboard on every completed transaction, tracks bus rules.
  always @(negedge clk) begin
    txn_t e;
    #1;
    if (!reset) begin
      halt_cyc  = -1;
      ret_cnt   = 0;
      halt_reqs = 0;
    end else begin
      chk("rden_wren_mutex", 64'(memory_rden & memory_wren), 64'd0);
      if (!memory_rden && !memory_wren) chk("idle_addr", 64'(memory_addr), 64'd0);
      if (retired) ret_cnt++;
      if (halted && halt_cyc < 0) halt_cyc = cyc;
      if (halted && (memory_rden || memory_wren)) halt_reqs++;
      if ((memory_rden || memory_wren) && memory_response) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_txn: wren=%b addr=%0h required no transaction", memory_wren, memory_addr);
        end else begin
          e = exp_q.pop_front();
          chk("txn_kind", 64'(memory_wren), 64'(e.w));
          chk("txn_addr", 64'(memory_addr), 64'(e.addr));
          if (e.w) chk("txn_data", 64'(memory_write_val), 64'(e.data));
        end
      end
    end
  end

  // Instruction-set reference: executes the program, queues expected bus traffic and timing.
  task automatic model(input int d, input int max_instr);
    logic [31:0] r [32];
    logic [31:0] pc, ins, imm, ea, val;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    int n;
    bit stop;
    for (int i = 0; i < 32; i++) r[i] = '0;
    pc = 0; exp_cyc = 1; exp_ret = 0; exp_halts = 0; n = 0; stop = 0;
    while (n < max_instr && !stop) begin
      ins = m_mem[pc[11:2]];
      exp_q.push_back('{1'b0, pc, 32'd0});
      n++;
      pc = pc + 32'd4;
      op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; fn = ins[5:0];
      imm = {{16{ins[15]}}, ins[15:0]};
      exp_cyc += 2 + d;
      val = '0;
      case (op)
        6'h00: begin
          case (fn)
            6'h20: val = r[rs] + r[rt];
            6'h22: val = r[rs] - r[rt];
            6'h24: val = r[rs] & r[rt];
            6'h25: val = r[rs] | r[rt];
            6'h2A: val = ($signed(r[rs]) < $signed(r[rt])) ? 32'd1 : 32'd0;
            default: stop = 1;
          endcase
          if (!stop) begin
            if (rd != 0) r[rd] = val;
            exp_cyc += 2; exp_ret++;
          end
        end
        6'h08: begin
          if (rt != 0) r[rt] = r[rs] + imm;
          exp_cyc += 2; exp_ret++;
        end
        6'h23: begin
          ea = r[rs] + imm;
          exp_q.push_back('{1'b0, ea, 32'd0});
          if (rt != 0) r[rt] = m_mem[ea[11:2]];
          exp_cyc += 3 + d; exp_ret++;
        end
        6'h2B: begin
          ea = r[rs] + imm;
          exp_q.push_back('{1'b1, ea, r[rt]});
          m_mem[ea[11:2]] = r[rt];
          exp_cyc += 2 + d; exp_ret++;
        end
        6'h04: begin
          if (r[rs] == r[rt]) pc = pc + imm * 32'd4;
          exp_cyc += 1; exp_ret++;
        end
        6'h02: begin
          pc = {4'd0, ins[25:0], 2'b00};
          exp_cyc += 1; exp_ret++;
        end
        6'h3F: begin
          exp_cyc += 1; exp_ret++; stop = 1;
        end
        default: stop = 1;
      endcase
      if (stop) exp_halts = 1;
    end
  endtask

  task automatic load_prog();
    for (int i = 0; i < 1024; i++) mem[i] = (i >= 128 && i < 256) ? $urandom : 32'd0;
    for (int i = 0; i < prog.size(); i++) mem[i] = prog[i];
  endtask

  task automatic run_test(input int d, input int max_instr);
    int budget, waited;
    reset = 1'b0;
    dly = d;
    exp_q.delete();
    for (int i = 0; i < 1024; i++) m_mem[i] = mem[i];
    model(d, max_instr);
    repeat (2) @(negedge clk);
    #2;
    chk("reset_addr", 64'(memory_addr), 64'd0);
    chk("reset_wval", 64'(memory_write_val), 64'd0);
    chk("reset_ctl", 64'({memory_rden, memory_wren, OpCode, halted, retired, state}), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    budget = exp_halts ? exp_cyc + 100 : 1000;
    waited = 0;
    while (waited < budget && !(exp_halts ? (halt_cyc >= 0) : (exp_q.size() == 0))) begin
      @(negedge clk);
      waited++;
    end
    if (!exp_halts) reset = 1'b0;
    chk("run_timeout", 64'(waited >= budget), 64'd0);
    if (exp_halts) begin
      repeat (8) @(negedge clk);
      #2;
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      chk("halt_cycle", 64'(halt_cyc), 64'(exp_cyc));
      chk("retired_count", 64'(ret_cnt), 64'(exp_ret));
      chk("halt_state", 64'({halted, state}), 64'({1'b1, 3'd5}));
      chk("halt_no_requests", 64'(halt_reqs), 64'd0);
    end
  endtask

  task automatic gen_random();
    int sel, pos;
    logic [4:0] a, b, c;
    logic [5:0] fn;
    prog.delete();
    for (int i = 1; i <= 8; i++) prog.push_back(iins(6'h08, 5'(i), 5'd0, 16'($urandom)));
    for (int k = 0; k < 20; k++) begin
      sel = $urandom_range(0, 9);
      a = 5'($urandom_range(0, 9));
      b = 5'($urandom_range(0, 9));
      c = 5'($urandom_range(0, 9));
      pos = prog.size();
      case ($urandom_range(0, 4))
        0: fn = 6'h20;
        1: fn = 6'h22;
        2: fn = 6'h24;
        3: fn = 6'h25;
        default: fn = 6'h2A;
      endcase
      case (sel)
        0, 1, 2, 3: prog.push_back(rins(fn, c, a, b));
        4: prog.push_back(iins(6'h08, c, a, 16'($urandom)));
        5: prog.push_back(iins(6'h23, c, 5'd0, 16'(32'h200 + 4 * $urandom_range(0, 15))));
        6: prog.push_back(iins(6'h2B, c, 5'd0, 16'(32'h200 + 4 * $urandom_range(0, 15))));
        7: prog.push_back(iins(6'h04, b, a, 16'($urandom_range(0, 2))));
        8: prog.push_back({6'h02, 26'(pos + 2)});
        default: prog.push_back(iins(6'h04, a, a, 16'd1));
      endcase
    end
    for (int i = 1; i <= 9; i++) prog.push_back(iins(6'h2B, 5'(i), 5'd0, 16'(32'h300 + 4 * i)));
    prog.push_back(HALT_INS);
  endtask

  initial begin
    reset = 1'b0;
    memory_response = 1'b0;
    memory_read_val = '0;

    // addi/addi/add/halt with zero and three wait states, then with the sum stored
    prog = '{iins(6'h08, 5'd1, 5'd0, 16'd5), iins(6'h08, 5'd2, 5'd0, 16'd7),
             rins(6'h20, 5'd3, 5'd1, 5'd2), HALT_INS};
    load_prog(); run_test(0, 100);
    load_prog(); run_test(3, 100);
    prog = '{iins(6'h08, 5'd1, 5'd0, 16'd5), iins(6'h08, 5'd2, 5'd0, 16'd7),
             rins(6'h20, 5'd3, 5'd1, 5'd2), iins(6'h2B, 5'd3, 5'd0, 16'h40), HALT_INS};
    load_prog(); run_test(0, 100);
    chk("sum_stored", 64'(mem[16]), 64'd12);

    // store then reload through 0x10 (program placed at 0x40 behind a jump)
    prog.delete();
    prog.push_back({6'h02, 26'd16});
    for (int i = 1; i < 16; i++) prog.push_back(32'd0);
    prog.push_back(iins(6'h08, 5'd3, 5'd0, 16'd12));
    prog.push_back(iins(6'h2B, 5'd3, 5'd0, 16'h10));
    prog.push_back(iins(6'h23, 5'd4, 5'd0, 16'h10));
    prog.push_back(iins(6'h2B, 5'd4, 5'd0, 16'h20));
    prog.push_back(HALT_INS);
    load_prog(); run_test(1, 100);
    chk("reload_value", 64'(mem[8]), 64'd12);

    // beq r1,r1,-1 at 0x8 spins; beq r1,r2,+2 with r1!=r2 falls through to 0xC
    prog = '{iins(6'h08, 5'd1, 5'd0, 16'd1), iins(6'h08, 5'd2, 5'd0, 16'd2),
             iins(6'h04, 5'd1, 5'd1, 16'hFFFF)};
    load_prog(); run_test(0, 12);
    prog = '{iins(6'h08, 5'd1, 5'd0, 16'd1), iins(6'h08, 5'd2, 5'd0, 16'd2),
             iins(6'h04, 5'd2, 5'd1, 16'd2), HALT_INS};
    load_prog(); run_test(0, 100);

    // illegal opcode and illegal funct both halt from DECODE
    prog = '{iins(6'h08, 5'd1, 5'd0, 16'd1), {6'h3E, 26'd0}};
    load_prog(); run_test(0, 100);
    prog = '{rins(6'h00, 5'd3, 5'd1, 5'd2)};
    load_prog(); run_test(2, 100);

    // R0 stays zero; signed slt of -1 < 1
    prog = '{iins(6'h08, 5'd0, 5'd0, 16'd9), iins(6'h08, 5'd5, 5'd0, 16'hFFFF),
             iins(6'h08, 5'd6, 5'd0, 16'd1), rins(6'h2A, 5'd7, 5'd5, 5'd6),
             iins(6'h2B, 5'd0, 5'd0, 16'h40), iins(6'h2B, 5'd7, 5'd0, 16'h44), HALT_INS};
    load_prog(); run_test(0, 100);
    chk("r0_stored", 64'(mem[16]), 64'd0);
    chk("slt_stored", 64'(mem[17]), 64'd1);

    // reset asserted while a fetch is waiting drops the request at once
    prog = '{iins(6'h08, 5'd1, 5'd0, 16'd5), HALT_INS};
    load_prog();
    exp_q.delete();
    dly = 7;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    chk("fetch_pending", 64'({memory_rden, memory_wren}), 64'({1'b1, 1'b0}));
    chk("fetch_addr", 64'(memory_addr), 64'd0);
    reset = 1'b0;
    #1;
    chk("async_drop", 64'({memory_rden, memory_wren, state}), 64'd0);
    chk("async_addr", 64'(memory_addr), 64'd0);
    repeat (3) @(negedge clk);

    for (int t = 0; t < 10; t++) begin
      gen_random();
      load_prog();
      run_test($urandom_range(0, 3), 1000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
